plic_target_ctrl: RTL
=====================

Name: plic_target_ctrl

Overview:
- Per-target arbitration and claim/complete controller for the PLIC. Sits between the per-source interrupt-pending handlers and one hart target.
- Each cycle, selects the highest-priority enabled pending source that is not in service and drives the target's external interrupt line.
- Sequences the claim handshake: returns the winning ID and pulses that source's claim input.
- Tracks in-service sources until the target writes complete.

Parameters:
- NSRC, 8, number of interrupt sources; IDs 1..NSRC, ID 0 means "no interrupt".
- PRIO_W, 3, priority field width; priority 0 means never interrupt.
- ID_W, 4, ID width; must satisfy 2^ID_W > NSRC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-high reset (name kept per codebase convention; 1 = reset).
- ip  in  NSRC  pending bits from the source handlers; bit i-1 is source i.
- ie  in  NSRC  per-source enable for this target.
- prio  in  NSRC*PRIO_W  flattened priorities; source i occupies bits [i*PRIO_W-1 -: PRIO_W].
- threshold  in  PRIO_W  target priority threshold.
- claim_req  in  1  target claim read strobe (single-cycle pulse).
- claim_ready  out  1  high when a claim is accepted (state IDLE).
- claim_vld  out  1  one-cycle pulse; claim_id is valid.
- claim_id  out  ID_W  claimed source ID, or 0.
- claim_o  out  NSRC  one-hot pulse to the source handlers' claim inputs.
- complete_req  in  1  target complete write strobe.
- complete_id  in  ID_W  ID being completed.
- eip  out  1  external interrupt pending to the target.

Behaviour:
- Reset: state=IDLE, in_service=0, best_id=0, best_prio=0. Outputs: eip=0, claim_vld=0, claim_id=0, claim_o=0, claim_ready=1.
- Eligible(i) = ip[i] & ie[i] & ~in_service[i] & (prio[i] != 0).
- Arbitration:
  - Combinational max over eligible sources. Ties go to the lowest ID.
  - Result registered into best_id/best_prio every cycle, giving 1-cycle latency from ip/ie/prio change to best_id.
  - best_id=0 and best_prio=0 when nothing is eligible.
- eip (registered) = (state==IDLE) & (best_id!=0) & (best_prio > threshold). Latency is 2 cycles from an ip rise to eip.
- FSM states:
  - IDLE: claim_ready=1. On claim_req, go to CLAIM.
  - CLAIM, one cycle:
    - claim_vld=1 and claim_id=best_id, sampled at the claim_req edge.
    - If best_id!=0 and best_prio>threshold: claim_o[best_id-1]=1 and in_service[best_id-1] is set at the end of this cycle.
    - Otherwise claim_id=0 and claim_o=0.
    - Next state: SETTLE.
  - SETTLE, one cycle: lets the handler's ip drop and best_id refresh. eip is forced 0. Next state: IDLE.
- claim_req outside IDLE is ignored: no response and no state change.
- Complete:
  - When complete_req=1 and 1<=complete_id<=NSRC, in_service[complete_id-1] clears at the next edge, in any state.
  - complete_id=0, complete_id>NSRC, or completing a source not in service: ignored, no effect.
- Simultaneous claim set and complete clear on the same bit in the same cycle: the set wins.
- Threshold or enable changes take effect on best_id/eip through the normal pipeline, with no special handling.
- Reset asserted mid-claim: all state returns to reset values immediately. Claimed-but-uncompleted sources lose in-service status.

Decomposition:
- Shared package plic_pkg:
  - constants NSRC, PRIO_W, ID_W.
  - FSM state encoding: IDLE=2'b00, CLAIM=2'b01, SETTLE=2'b10.
  - ID_NONE=0.
- One natural sub-module: plic_prio_max.
  - Purely combinational max tree over eligible sources; outputs best_id and best_prio; lowest ID wins ties.
  - Reused by every target instance.

Test Plan:
- Reset held, then released with ip=0 -> eip=0, claim_ready=1, claim_id=0. A claim_req pulse -> claim_vld one cycle later with claim_id=0 and claim_o=0.
- Single source, highest ID: ie=all, prio[8]=5, threshold=2, ip[7] rises -> eip=1 two cycles later. claim_req -> claim_vld with claim_id=8 and claim_o=8'h80 for one cycle, eip=0 during SETTLE, in_service[7]=1.
- Tie-break: sources 3 and 6 both pending with prio=4 -> claim_id=3. complete_id=3 -> next claim returns 6.
- Threshold, priority 0 and enable masking:
  - prio[2]=3, threshold=3, ip[1]=1 -> eip stays 0 and a claim returns 0.
  - threshold drops to 2 -> eip=1.
  - ie[1]=0 -> eip=0.
  - prio[2]=0 -> eip stays 0 even with ie[1]=1.
- In-service masking: claim source 5, ip[4] re-raises -> not re-presented and eip=0. complete_id=5 -> eip=1 two cycles later. complete_id=0 and complete_id=9 -> no change.
- Edge cases:
  - A second claim_req during CLAIM/SETTLE is ignored.
  - claim of source 4 and complete_id=4 in the same cycle -> in_service[3] stays 1.
  - Reset asserted during CLAIM -> in_service=0 and outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared constants and FSM encoding for the PLIC target controller.
package plic_pkg;

  localparam int NSRC   = 8;  // sources, IDs 1..NSRC
  localparam int PRIO_W = 3;  // priority width, 0 = never interrupt
  localparam int ID_W   = 4;  // 2**ID_W must exceed NSRC

  localparam logic [ID_W-1:0] ID_NONE = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CLAIM  = 2'b01,
    SETTLE = 2'b10
  } state_t;

endpackage

// File: rtl/plic_target_ctrl_if.sv
// Target-side bus: pending/enable/priority inputs, claim and complete handshakes, eip.
interface plic_target_ctrl_if;
  import plic_pkg::*;

  logic [NSRC-1:0]        ip;
  logic [NSRC-1:0]        ie;
  logic [NSRC*PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]      threshold;
  logic                   claim_req;
  logic                   claim_ready;
  logic                   claim_vld;
  logic [ID_W-1:0]        claim_id;
  logic [NSRC-1:0]        claim_o;
  logic                   complete_req;
  logic [ID_W-1:0]        complete_id;
  logic                   eip;

  modport master (
    output ip, ie, prio, threshold, claim_req, complete_req, complete_id,
    input  claim_ready, claim_vld, claim_id, claim_o, eip
  );

  modport slave (
    input  ip, ie, prio, threshold, claim_req, complete_req, complete_id,
    output claim_ready, claim_vld, claim_id, claim_o, eip
  );

endinterface

// File: rtl/plic_prio_max.sv
// Combinational max-priority selection over eligible sources; lowest ID wins ties.
module plic_prio_max
  import plic_pkg::*;
(
  input  logic [NSRC-1:0]        elig_i,
  input  logic [NSRC*PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]        best_id_o,
  output logic [PRIO_W-1:0]      best_prio_o
);

  logic [ID_W-1:0]   id_acc;
  logic [PRIO_W-1:0] prio_acc;

  // Ascending scan with a strict compare so an equal later source never displaces an earlier one.
  always_comb begin
    id_acc   = ID_NONE;
    prio_acc = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (elig_i[i-1] && (prio_i[i*PRIO_W-1 -: PRIO_W] > prio_acc)) begin
        id_acc   = ID_W'(i);
        prio_acc = prio_i[i*PRIO_W-1 -: PRIO_W];
      end
    end
    best_id_o   = id_acc;
    best_prio_o = prio_acc;
  end

endmodule

// File: rtl/plic_target_ctrl.sv
// Per-target PLIC arbiter plus claim/complete sequencer and in-service tracking.
module plic_target_ctrl
  import plic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,  // active-high asynchronous reset
  plic_target_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  logic [NSRC-1:0]   in_service_q, in_service_d;
  logic [ID_W-1:0]   best_id_q, best_id_c;
  logic [PRIO_W-1:0] best_prio_q, best_prio_c;
  logic [ID_W-1:0]   cap_id_q, cap_id_d;
  logic              eip_q, eip_d;

  logic [NSRC-1:0]   elig;
  logic [NSRC-1:0]   claim_oh;
  logic [NSRC-1:0]   clr_oh;
  logic [ID_W-1:0]   claim_id_c;
  logic              claim_ready_c;
  logic              claim_vld_c;
  logic              claim_hit;

  // Eligibility: pending, enabled, not already being serviced, nonzero priority.
  always_comb begin
    elig = '0;
    for (int i = 1; i <= NSRC; i++) begin
      elig[i-1] = bus.ip[i-1] & bus.ie[i-1] & ~in_service_q[i-1] &
                  (bus.prio[i*PRIO_W-1 -: PRIO_W] != '0);
    end
  end

  plic_prio_max u_prio_max (
    .elig_i      (elig),
    .prio_i      (bus.prio),
    .best_id_o   (best_id_c),
    .best_prio_o (best_prio_c)
  );

  // The registered winner only counts once it also clears the threshold.
  assign claim_hit = (best_id_q != ID_NONE) && (best_prio_q > bus.threshold);

  // Claim sequencer: IDLE accepts, CLAIM presents the captured ID, SETTLE waits for ip/best to refresh.
  always_comb begin
    state_d       = state_q;
    cap_id_d      = cap_id_q;
    claim_ready_c = 1'b0;
    claim_vld_c   = 1'b0;
    claim_id_c    = ID_NONE;
    unique case (state_q)
      IDLE: begin
        claim_ready_c = 1'b1;
        if (bus.claim_req) begin
          state_d  = CLAIM;
          cap_id_d = claim_hit ? best_id_q : ID_NONE;
        end
      end
      CLAIM: begin
        claim_vld_c = 1'b1;
        claim_id_c  = cap_id_q;
        state_d     = SETTLE;
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-hot decode of the claimed and completed IDs; out-of-range IDs decode to nothing.
  always_comb begin
    claim_oh = '0;
    clr_oh   = '0;
    for (int i = 1; i <= NSRC; i++) begin
      claim_oh[i-1] = (claim_id_c == ID_W'(i));
      clr_oh[i-1]   = bus.complete_req && (bus.complete_id == ID_W'(i));
    end
    // Set after clear so a same-cycle claim of a completing source keeps it in service.
    in_service_d = (in_service_q & ~clr_oh) | claim_oh;
    eip_d        = (state_q == IDLE) && claim_hit;
  end

  // State, arbitration pipeline and in-service register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      in_service_q <= '0;
      best_id_q    <= ID_NONE;
      best_prio_q  <= '0;
      cap_id_q     <= ID_NONE;
      eip_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_service_q <= in_service_d;
      best_id_q    <= best_id_c;
      best_prio_q  <= best_prio_c;
      cap_id_q     <= cap_id_d;
      eip_q        <= eip_d;
    end
  end

  assign bus.claim_ready = claim_ready_c;
  assign bus.claim_vld   = claim_vld_c;
  assign bus.claim_id    = claim_id_c;
  assign bus.claim_o     = claim_oh;
  assign bus.eip         = eip_q;

endmodule
